// File: rtl/forward_result_buffer.sv
// forward_result_buffer
//   Keeps in-flight results in program order beside the ROB and answers up to
//   NLOOK operand-forwarding tag lookups per cycle with {Data, Flag}.
//   Flag is active-low: 0 = hit with valid Data, 1 = miss with Data = 0.
// Ports
//   clk, rst_n                    clock, async active-low reset
//   Flush                         sync clear of every entry (mispredict)
//   AllocEn/AllocTag/AllocReady   dispatch allocates the tail entry
//   CompEn/CompTag/CompData       CDB completion broadcast
//   RetireValid/Tag/Data/Ack      in-order drain of the head entry
//   LookTag/LookData/LookFlag     NLOOK flattened lookup ports, port k at [32k+:32]
//   Count                         occupied entries

// One lookup port: scans the buffer from head to tail. Later hits in the scan
// overwrite earlier ones, so the youngest matching ready entry wins.
module fwdLookupLane #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic [31:0]            lookTag,
  input  logic                   compEn,
  input  logic [31:0]            compTag,
  input  logic [31:0]            compData,
  input  logic [DEPTH-1:0]       entValid,
  input  logic [DEPTH-1:0]       entReady,
  input  logic [DEPTH-1:0][31:0] entTag,
  input  logic [DEPTH-1:0][31:0] entData,
  input  logic [AW-1:0]          head,
  output logic [31:0]            lookData,
  output logic                   lookFlag
);
  logic          pendHit;
  logic          storHit;
  logic [31:0]   storData;
  logic [AW-1:0] idx;

  always_comb begin
    pendHit  = 1'b0;
    storHit  = 1'b0;
    storData = '0;
    idx      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      idx = head + AW'(j);
      if (entValid[idx] && entTag[idx] == lookTag) begin
        if (!entReady[idx]) pendHit = 1'b1;
        else begin
          storHit  = 1'b1;
          storData = entData[idx];
        end
      end
    end

    lookFlag = 1'b1;
    lookData = '0;
    if (lookTag != '0) begin
      // Completion in flight to a waiting entry is forwarded the same cycle.
      if (compEn && compTag == lookTag && pendHit) begin
        lookFlag = 1'b0;
        lookData = compData;
      end else if (storHit) begin
        lookFlag = 1'b0;
        lookData = storData;
      end
    end
  end
endmodule

module forward_result_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int NLOOK = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Flush,
  input  logic                  AllocEn,
  input  logic [31:0]           AllocTag,
  output logic                  AllocReady,
  input  logic                  CompEn,
  input  logic [31:0]           CompTag,
  input  logic [31:0]           CompData,
  output logic                  RetireValid,
  output logic [31:0]           RetireTag,
  output logic [31:0]           RetireData,
  input  logic                  RetireAck,
  input  logic [32*NLOOK-1:0]   LookTag,
  output logic [32*NLOOK-1:0]   LookData,
  output logic [NLOOK-1:0]      LookFlag,
  output logic [AW:0]           Count
);
  logic [DEPTH-1:0]       entValid, entReady;
  logic [DEPTH-1:0][31:0] entTag, entData;
  logic [AW-1:0]          head, tail;
  logic                   allocFire, retireFire;

  // Full is judged on the registered Count only; a retire in the same cycle
  // does not open a slot for this cycle's alloc.
  assign AllocReady  = (Count != (AW+1)'(DEPTH));
  assign RetireValid = entValid[head] && entReady[head];
  assign RetireTag   = entTag[head];
  assign RetireData  = entData[head];
  assign allocFire   = AllocEn && AllocReady;
  assign retireFire  = RetireAck && RetireValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entValid <= '0;
      entReady <= '0;
      entTag   <= '0;
      entData  <= '0;
      head     <= '0;
      tail     <= '0;
      Count    <= '0;
    end else if (Flush) begin
      entValid <= '0;
      entReady <= '0;
      entTag   <= '0;
      entData  <= '0;
      head     <= '0;
      tail     <= '0;
      Count    <= '0;
    end else begin
      // First completion wins: only not-ready entries capture the broadcast.
      for (int i = 0; i < DEPTH; i++) begin
        if (CompEn && entValid[i] && !entReady[i] && entTag[i] == CompTag) begin
          entReady[i] <= 1'b1;
          entData[i]  <= CompData;
        end
      end
      if (retireFire) begin
        entValid[head] <= 1'b0;
        entReady[head] <= 1'b0;
        entTag[head]   <= '0;
        entData[head]  <= '0;
        head           <= head + 1'b1;
      end
      // Tail slot is empty whenever alloc fires, so a same-cycle completion
      // of the same tag cannot have matched it; the entry stays not-ready.
      if (allocFire) begin
        entValid[tail] <= 1'b1;
        entReady[tail] <= 1'b0;
        entTag[tail]   <= AllocTag;
        entData[tail]  <= '0;
        tail           <= tail + 1'b1;
      end
      Count <= Count + (AW+1)'(allocFire) - (AW+1)'(retireFire);
    end
  end

  for (genvar k = 0; k < NLOOK; k++) begin : gLane
    fwdLookupLane #(.DEPTH(DEPTH), .AW(AW)) uLane (
      .lookTag  (LookTag[32*k +: 32]),
      .compEn   (CompEn),
      .compTag  (CompTag),
      .compData (CompData),
      .entValid (entValid),
      .entReady (entReady),
      .entTag   (entTag),
      .entData  (entData),
      .head     (head),
      .lookData (LookData[32*k +: 32]),
      .lookFlag (LookFlag[k])
    );
  end
endmodule
